// File: rtl/serial_word_receiver.sv
// Serial-to-word receiver: collects en-qualified bits into WIDTH-bit words on a valid/ready port.
// Optional even-parity framing bit enabled by `define PARITY_CHECK_EN.
module serial_word_receiver #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;

  logic             w_bit;
  logic             w_data_bit;
  logic             w_last;
  logic             w_accept;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_shift_in;
  logic [WIDTH-1:0] w_word;

  // clr outranks en: the bit presented alongside clr is discarded.
  assign w_bit  = en & ~clr;
  assign w_last = w_bit & (r_bit_cnt == LAST_CNT);

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shift_in = {d, r_shift[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shift_in = {r_shift[WIDTH-2:0], d};
    end
  endgenerate

`ifdef PARITY_CHECK_EN
  logic r_parity_err;

  // The trailing parity bit is never shifted in; the data word is already complete.
  assign w_data_bit = w_bit & (r_bit_cnt < CNT_W'(WIDTH));
  assign w_word     = r_shift;
`else
  assign w_data_bit = w_bit;
  assign w_word     = w_shift_in;
`endif

  assign w_accept = r_out_valid & out_ready;
  assign w_load   = w_last & (~r_out_valid | out_ready);
  assign w_drop   = w_last & r_out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (clr || w_last) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_bit) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_data_bit) begin
        r_shift <= w_shift_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Even parity over data plus parity bit; only words actually loaded update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= (^r_shift) ^ d;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: LSB-first and MSB-first instances share one serial stream,
// expected words are queued when sent and compared when the consumer accepts them.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       d = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;

  logic [7:0] out_data0, out_data1;
  logic       out_valid0, out_valid1;
  logic       overrun0, overrun1;
  logic       parity_err0, parity_err1;

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .clr(clr),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .overrun(overrun0), .parity_err(parity_err0)
  );

  serial_word_receiver #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .clr(clr),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .overrun(overrun1), .parity_err(parity_err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Inputs change 1 time unit after posedge and are sampled on the following posedge.
  task automatic drive(input logic e, input logic b, input logic c);
    en  = e;
    d   = b;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  // First bit on the wire is w[0]; the MSB-first instance therefore sees rev8(w).
  task automatic send_raw(input logic [7:0] w, input logic pbit, input logic exp_perr,
                          input bit push, input int gap);
    exp_t e;
    if (push) begin
      e.d0   = w;
      e.d1   = rev8(w);
      e.perr = exp_perr;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, w[i], 1'b0);
      repeat (gap) drive(1'b0, 1'b0, 1'b0);
    end
`ifdef PARITY_CHECK_EN
    drive(1'b1, pbit, 1'b0);
`endif
    en = 1'b0;
    d  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit push, input int gap);
    send_raw(w, ^w, 1'b0, push, gap);
  endtask

  // Consumer-side scoreboard: an accept happens on the posedge after this negedge.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'd0, out_data0}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("data_lsb", {24'd0, out_data0}, {24'd0, e.d0});
        chk("data_msb", {24'd0, out_data1}, {24'd0, e.d1});
        chk("valid_msb", {31'd0, out_valid1}, 32'd1);
        chk("perr", {31'd0, parity_err0}, {31'd0, e.perr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_data", {24'd0, out_data0}, 32'd0);
    chk("rst_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_overrun", {31'd0, overrun0}, 32'd0);
    chk("rst_perr", {31'd0, parity_err0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Basic word; out_valid lasts exactly one cycle with the consumer ready.
    out_ready = 1'b1;
    send_word(8'hA5, 1'b1, 0);
    @(negedge clk);
    chk("t2_valid_hi", {31'd0, out_valid0}, 32'd1);
    chk("t2_data", {24'd0, out_data0}, 32'hA5);
    @(negedge clk);
    chk("t2_valid_lo", {31'd0, out_valid0}, 32'd0);

    // Gaps between bits, and a lone trailing one (0x01 as seen MSB-first).
    send_word(8'hA5, 1'b1, 2);
    send_word(8'h80, 1'b1, 2);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("t3_msb_01", {24'd0, out_data1}, 32'h01);

    // Stall: second word is dropped, first one held, overrun sticks.
    out_ready = 1'b0;
    send_word(8'h3C, 1'b1, 0);
    send_word(8'hC3, 1'b0, 0);
    @(negedge clk);
    chk("t4_hold_data", {24'd0, out_data0}, 32'h3C);
    chk("t4_hold_valid", {31'd0, out_valid0}, 32'd1);
    chk("t4_overrun", {31'd0, overrun0}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_valid_lo", {31'd0, out_valid0}, 32'd0);
    chk("t4_overrun_sticky", {31'd0, overrun0}, 32'd1);

    // Reset mid-word with a held word and overrun set clears everything.
    out_ready = 1'b0;
    send_word(8'h5A, 1'b0, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t1_data", {24'd0, out_data0}, 32'd0);
    chk("t1_valid", {31'd0, out_valid0}, 32'd0);
    chk("t1_overrun", {31'd0, overrun0}, 32'd0);
    chk("t1_perr", {31'd0, parity_err0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_word(8'hA5, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b0);

    // Back-to-back words with continuous en.
    send_word(8'h11, 1'b1, 0);
    send_word(8'h22, 1'b1, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    chk("t5_overrun", {31'd0, overrun0}, 32'd0);

    // clr discards a partial word (and the bit presented with it).
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    send_word(8'h5A, 1'b1, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    chk("t6_clr_data", {24'd0, out_data0}, 32'h5A);

`ifdef PARITY_CHECK_EN
    send_raw(8'h07, 1'b0, 1'b1, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b0);
    send_raw(8'h07, 1'b1, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
